// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: control-unit side of the ALU sequencer.
// Start/done handshake, operands and captured result registers.
interface alu_seq_ctrl_if;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] z_lo;
  logic [31:0] z_hi;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        err;
  logic        halted;

  modport master (
    output start, opcode, a_in, b_in,
    input  z_lo, z_hi, hi_out, lo_out,
    input  busy, done, err, halted
  );

  modport slave (
    input  start, opcode, a_in, b_in,
    output z_lo, z_hi, hi_out, lo_out,
    output busy, done, err, halted
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: holds ALU inputs for a per-opcode cycle count,
// then captures the 64-bit result into Z and HI/LO.
module alu_seq_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic         clk,
  input  logic         clear,
  alu_seq_ctrl_if.slave cu,
  output logic [31:0]  alu_A,
  output logic [31:0]  alu_B,
  output logic [4:0]   alu_opcode,
  input  logic [63:0]  alu_C
);

  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [1:0] {
    IDLE, EXEC, DONE, HALTED
  } state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] n_load;
  logic [4:0]  op_q;
  logic [31:0] z_lo_q, z_hi_q, hi_q, lo_q;
  logic        err_q;

  logic is_mul, is_div, is_mfhi, is_mflo;
  logic is_halt, is_ill, is_none, div0;

  assign is_mul  = (op_q == OP_MUL);
  assign is_div  = (op_q == OP_DIV);
  assign is_mfhi = (op_q == OP_MFHI);
  assign is_mflo = (op_q == OP_MFLO);
  assign is_halt = (op_q == OP_HALT);
  assign is_ill  = (op_q > OP_HALT);
  assign is_none = (op_q >= OP_BR && op_q <= OP_OUT)
                 || (op_q == OP_NOP);
  assign div0    = is_div && (alu_B == '0);

  assign n_load =
    (cu.opcode == OP_MUL) ? CW'(MUL_CYCLES - 1) :
    (cu.opcode == OP_DIV) ? CW'(DIV_CYCLES - 1) :
    '0;

  // state register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: start only matters in IDLE; halt skips DONE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cu.start) state_nxt = EXEC;
      EXEC:    if (cnt == '0)
                 state_nxt = is_halt ? HALTED : DONE;
      DONE:    state_nxt = IDLE;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch, hold counter and result capture
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt    <= '0;
      op_q   <= OP_NOP;
      alu_A  <= '0;
      alu_B  <= '0;
      z_lo_q <= '0;
      z_hi_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      err_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (cu.start) begin
        op_q  <= cu.opcode;
        alu_A <= cu.a_in;
        alu_B <= cu.b_in;
        cnt   <= n_load;
      end
    end else if (state == EXEC) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        err_q <= is_ill || div0;
        unique case (1'b1)
          is_mul, (is_div && !div0): begin
            z_lo_q <= alu_C[31:0];
            z_hi_q <= alu_C[63:32];
            hi_q   <= alu_C[63:32];
            lo_q   <= alu_C[31:0];
          end
          is_mfhi: begin
            z_lo_q <= hi_q;
            z_hi_q <= '0;
          end
          is_mflo: begin
            z_lo_q <= lo_q;
            z_hi_q <= '0;
          end
          (is_none || is_halt || is_ill || div0): ;
          default: begin
            z_lo_q <= alu_C[31:0];
            z_hi_q <= '0;
          end
        endcase
      end
    end
  end

  assign alu_opcode = (state == EXEC) ? op_q : OP_NOP;

  assign cu.z_lo   = z_lo_q;
  assign cu.z_hi   = z_hi_q;
  assign cu.hi_out = hi_q;
  assign cu.lo_out = lo_q;
  assign cu.busy   = (state != IDLE);
  assign cu.done   = (state == DONE);
  assign cu.err    = (state == DONE) && err_q;
  assign cu.halted = (state == HALTED);

endmodule
